ysyx_lsu_resp: RTL and testbench
================================

# ysyx_lsu_resp

Memory-side responder for the LSU load/store bus. It accepts one load or store request at a time from the LSU bus ports and services it from an internal byte-enabled word SRAM after a fixed, parameterised latency. It answers a load with a one-cycle `lsu_rvalid` pulse carrying right-aligned data, and a store with a one-cycle `lsu_wready` pulse. It sits between the LSU and the memory model/arbiter and gives the L1D a deterministic backing store for simulation and bring-up.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; only 32 is supported.
- `MEM_WORDS`, 1024, SRAM depth in 32-bit words; must be a power of two.
- `LATENCY`, 2, cycles from request acceptance to response; legal range is 1..15.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, **synchronous, active-high**.
- `lsu_araddr` in ADDR_W: load byte address.
- `lsu_arvalid` in 1: load request; held high by the LSU until `lsu_rvalid`.
- `lsu_rstrb` in 8: load size mask; legal values 8'h1, 8'h3, 8'hf.
- `lsu_rdata` out DATA_W: load data, right-aligned.
- `lsu_rvalid` out 1: load response pulse.
- `lsu_awaddr` in ADDR_W: store byte address.
- `lsu_awvalid` in 1: store address valid.
- `lsu_wdata` in DATA_W: store data, right-aligned (byte 0 is the LSB).
- `lsu_wstrb` in 8: store size mask; legal values 8'h1, 8'h3, 8'hf.
- `lsu_wvalid` in 1: store data valid.
- `lsu_wready` out 1: store completion pulse.

## Operation
- FSM states:
  - IDLE: ready to accept a request.
  - BUSY: latency counter running.
  - RESP: response cycle.
  - HOLD: one-cycle guard after the response.
- IDLE accepts a store when `lsu_awvalid & lsu_wvalid` is high, and a load when `lsu_arvalid` is high.
  - If a store and a load are presented together, the store wins. The load stays pending and is accepted later.
  - On acceptance the block latches address, strobe, data, and a type bit, loads the counter with `LATENCY-1`, and moves to BUSY. With `LATENCY`=1 it moves directly to RESP.
- BUSY decrements the counter and moves to RESP when the counter reaches 0.
- RESP for a load:
  - `lsu_rvalid`=1.
  - `lsu_rdata` = (word >> 8·off), masked to the rstrb size (LSU applies sign extension).
- RESP for a store:
  - `lsu_wready`=1.
  - The SRAM write commits in this cycle, with byte enables = `lsu_wstrb[3:0] << off` and data = `lsu_wdata << 8·off`.
- HOLD ignores all requests for one cycle. This absorbs the LSU's valid, which drops one cycle after the response. The FSM then returns to IDLE.
- Address decode:
  - Word index is `addr[log2(MEM_WORDS)+1:2]`; upper bits are ignored, so the address space aliases and wraps.
  - Byte offset `off` is `addr[1:0]`.
- Misaligned access that crosses a word boundary (off + size > 4):
  - Store: bytes beyond byte 3 are dropped.
  - Load: vacated high bytes read as 0.
  - No error is signalled.
- A strobe value other than the legal set is treated as 8'hf.
- `lsu_rdata` is 0 whenever `lsu_rvalid` is 0.
- Input changes after acceptance are ignored; the latched copy is used.

## Timing
- Request sampled in IDLE at edge T → response high during cycle T+`LATENCY`, for exactly one cycle.
- HOLD occupies cycle T+`LATENCY`+1. The earliest next acceptance is at edge T+`LATENCY`+2.
- Store data is visible to a load accepted at or after the store's HOLD cycle. There is no forwarding from in-flight stores.
- Reset values: state=IDLE, counter=0, `lsu_rvalid`=0, `lsu_wready`=0, `lsu_rdata`=0, latched registers=0. SRAM contents are not reset.
- Reset mid-operation:
  - Any transaction in BUSY or RESP is abandoned; no SRAM write and no response occur.
  - An LSU valid still high after reset is accepted as a fresh request.
- Counter width is 4 bits and never wraps, since `LATENCY` ≤ 15.

## Structure
- Add FSM state encodings `ysyx_LSURESP_IDLE/BUSY/RESP/HOLD` (2-bit) to `ysyx_macro.v`.
- Add byte-strobe constants (SB=8'h1, SH=8'h3, SW=8'hf) to `ysyx_macro.v`.
- One sub-module, `ysyx_sram_1rw`:
  - Word-addressed, synchronous write with 4-bit byte enable.
  - Combinational read of the latched index.
- The top level holds the FSM, counter, alignment shifters, and response registers.

## Test plan
- Store then load: SW 0xDEADBEEF to 0x80000010 → `lsu_wready` pulse at T+2. LW from 0x80000010 → `lsu_rdata`=0xDEADBEEF with a single `lsu_rvalid` pulse at T+2.
- Sub-word access:
  - SB 0x000000AA to 0x80000013, then LW 0x80000010 → 0xAAADBEEF.
  - LH 0x80000012 → 0x0000AAAD.
- Simultaneous request: store and load raised in the same IDLE cycle → `lsu_wready` first. The load is accepted at T+4, `lsu_rvalid` at T+6 returns the new store data.
- HOLD guard: `lsu_arvalid` held high one cycle past `lsu_rvalid` → exactly one `lsu_rvalid` pulse, no duplicate.
- Reset mid-store: SW 0x12345678 to 0x80000020 with `rst` at T+1 → no `lsu_wready`, and a later LW returns the prior contents. All outputs read 0 in the cycle after reset.
- Aliasing and misalignment (`MEM_WORDS`=1024):
  - SW to 0x80001000 then LW 0x80000000 → same data.
  - SW 0x11223344 to 0x80000006 → only bytes 6–7 are written (0x3344). LW 0x80000006 → 0x00003344.

Source files
------------

// File: rtl/ysyx_lsu_resp_pkg.sv
// Purpose: shared types and constants for the LSU memory-side responder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package ysyx_lsu_resp_pkg;

    // Responder FSM encodings
    typedef enum logic [1:0] {
        ysyx_LSURESP_IDLE = 2'd0,
        ysyx_LSURESP_BUSY = 2'd1,
        ysyx_LSURESP_RESP = 2'd2,
        ysyx_LSURESP_HOLD = 2'd3
    } lsu_resp_state_t;

    // Byte-strobe encodings used on rstrb/wstrb
    localparam logic [7:0] STRB_SB = 8'h01;
    localparam logic [7:0] STRB_SH = 8'h03;
    localparam logic [7:0] STRB_SW = 8'h0f;

    // Latency counter width; LATENCY is limited to 15 so it never wraps
    localparam int CNT_W = 4;

    // Collapse an 8-bit strobe into a 4-bit right-aligned byte mask.
    // Anything outside the legal set behaves as a full word.
    function automatic logic [3:0] size_mask(input logic [7:0] strb);
        case (strb)
            STRB_SB: return 4'h1;
            STRB_SH: return 4'h3;
            default: return 4'hf;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_lsu_resp_if.sv
// Purpose: LSU load/store bus between the LSU (master) and the responder (slave).
// Latency: n/a (wires only).
// Backpressure: master holds its valids until the matching response pulse.
// Ports: ar* load request, r* load response, aw*/w* store request, wready store completion.
interface ysyx_lsu_resp_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [7:0]        rstrb;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wstrb;
    logic              wvalid;
    logic              wready;

    modport master (
        output araddr, arvalid, rstrb, awaddr, awvalid, wdata, wstrb, wvalid,
        input  rdata, rvalid, wready
    );

    modport slave (
        input  araddr, arvalid, rstrb, awaddr, awvalid, wdata, wstrb, wvalid,
        output rdata, rvalid, wready
    );
endinterface

// File: rtl/ysyx_sram_1rw.sv
// Purpose: word-addressed single-port SRAM with 4-bit byte-enable writes.
// Latency: write commits at the clock edge; read is combinational from idx.
// Backpressure: none, always ready.
// Ports: clk, we, be (byte enables), idx (word index), wdata, rdata.
module ysyx_sram_1rw #(
    parameter int WORDS = 1024,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    // Contents are deliberately not reset
    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/ysyx_lsu_resp.sv
// Purpose: LSU responder servicing one load/store at a time from an internal SRAM.
// Latency: request sampled at edge T -> one-cycle response during cycle T+LATENCY.
// Backpressure: requests wait in IDLE; a HOLD cycle after each response ignores stale valids.
// Ports: clk, rst (sync active-high), lsu (slave side of the LSU bus).
module ysyx_lsu_resp
    import ysyx_lsu_resp_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst,
    ysyx_lsu_resp_if.slave  lsu
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);

    lsu_resp_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_store, acc_load;

    // Latched request; only the word index and byte offset of the address matter
    logic              is_store_q;
    logic [IDX_W+1:0]  addr_q;
    logic [3:0]        size_q;
    logic [DATA_W-1:0] wdata_q;

    // Address bits above the SRAM index alias away
    logic unused_addr_bits;
    assign unused_addr_bits = ^{lsu.araddr[ADDR_W-1:IDX_W+2], lsu.awaddr[ADDR_W-1:IDX_W+2]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_store = 1'b0;
        acc_load  = 1'b0;
        case (state_q)
            ysyx_LSURESP_IDLE: begin
                // Store has priority; a concurrent load stays pending on the bus
                if (lsu.awvalid && lsu.wvalid) begin
                    acc_store = 1'b1;
                end else if (lsu.arvalid) begin
                    acc_load = 1'b1;
                end
                if (acc_store || acc_load) begin
                    cnt_d   = LAT_INIT;
                    state_d = (LATENCY == 1) ? ysyx_LSURESP_RESP : ysyx_LSURESP_BUSY;
                end
            end
            ysyx_LSURESP_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ysyx_LSURESP_RESP;
                end
            end
            ysyx_LSURESP_RESP: state_d = ysyx_LSURESP_HOLD;
            ysyx_LSURESP_HOLD: state_d = ysyx_LSURESP_IDLE;
            default:           state_d = ysyx_LSURESP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ysyx_LSURESP_IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc_store) begin
                is_store_q <= 1'b1;
                addr_q     <= lsu.awaddr[IDX_W+1:0];
                size_q     <= size_mask(lsu.wstrb);
                wdata_q    <= lsu.wdata;
            end else if (acc_load) begin
                is_store_q <= 1'b0;
                addr_q     <= lsu.araddr[IDX_W+1:0];
                size_q     <= size_mask(lsu.rstrb);
            end
        end
    end

    logic [1:0]        off;
    logic [IDX_W-1:0]  idx;
    logic              in_resp;
    logic              sram_we;
    logic [3:0]        sram_be;
    logic [DATA_W-1:0] sram_wdata, sram_rdata;
    logic [DATA_W-1:0] load_shift, load_mask;

    assign off     = addr_q[1:0];
    assign idx     = addr_q[IDX_W+1:2];
    // A reset landing on the response cycle abandons the transaction
    assign in_resp = (state_q == ysyx_LSURESP_RESP) && !rst;

    // Shifting in 4/32-bit context drops bytes that would cross into the next word
    assign sram_we    = in_resp && is_store_q;
    assign sram_be    = size_q << off;
    assign sram_wdata = wdata_q << {off, 3'b000};

    ysyx_sram_1rw #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (clk),
        .we    (sram_we),
        .be    (sram_be),
        .idx   (idx),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    // Right-shift zero-fills vacated high bytes of a misaligned load
    assign load_shift = sram_rdata >> {off, 3'b000};
    assign load_mask  = {{8{size_q[3]}}, {8{size_q[2]}}, {8{size_q[1]}}, {8{size_q[0]}}};

    assign lsu.rvalid = in_resp && !is_store_q;
    assign lsu.wready = in_resp && is_store_q;
    assign lsu.rdata  = lsu.rvalid ? (load_shift & load_mask) : '0;
endmodule

// File: tb/tb_ysyx_lsu_resp.sv
module tb_ysyx_lsu_resp;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_lsu_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_lsu_resp #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MEM_WORDS (1024),
        .LATENCY   (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Observation results of the last window
    int          first_w, cnt_w, first_r, cnt_r, leak;
    logic [31:0] data_r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Watch n cycles after the request edge T; sample k lies in cycle T+k.
    // Valids are dropped and reset pulsed at the requested sample points.
    task automatic observe(input int n, input int st_drop, input int ld_drop, input int rst_k);
        first_w = -1; cnt_w = 0; first_r = -1; cnt_r = 0; leak = 0; data_r = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (bus.wready) begin
                cnt_w++;
                if (first_w < 0) first_w = k;
            end
            if (bus.rvalid) begin
                cnt_r++;
                if (first_r < 0) begin
                    first_r = k;
                    data_r  = bus.rdata;
                end
            end else if (bus.rdata != 32'h0) begin
                leak++;
            end
            if (k == st_drop) begin
                bus.awvalid = 1'b0;
                bus.wvalid  = 1'b0;
            end
            if (k == ld_drop) bus.arvalid = 1'b0;
            if (k == rst_k) rst = 1'b1;
            if (k == rst_k + 1) rst = 1'b0;
        end
    endtask

    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] s);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk);
        observe(8, LAT + 2, 0, -10);
        chk({tag, "_wlat"}, first_w, LAT);
        chk({tag, "_wcnt"}, cnt_w, 1);
        chk({tag, "_rcnt"}, cnt_r, 0);
    endtask

    // Load valid is held through the HOLD cycle, so a duplicate would show in cnt_r
    task automatic do_load(input string tag, input logic [31:0] a, input logic [7:0] s,
                           input logic [31:0] exp);
        bus.araddr = a; bus.rstrb = s; bus.arvalid = 1'b1;
        @(posedge clk);
        observe(8, 0, LAT + 2, -10);
        chk({tag, "_rlat"}, first_r, LAT);
        chk({tag, "_rcnt"}, cnt_r, 1);
        chk({tag, "_data"}, data_r, exp);
        chk({tag, "_leak"}, leak, 0);
        chk({tag, "_wcnt"}, cnt_w, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rstrb = '0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0;
        bus.wstrb = '0;  bus.wvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_rdata",  bus.rdata,  0);
        rst = 1'b0;
        @(negedge clk);

        // Store then load
        do_store("sw0", 32'h8000_0010, 32'hDEAD_BEEF, 8'h0f);
        do_load ("lw0", 32'h8000_0010, 8'h0f, 32'hDEAD_BEEF);

        // Sub-word accesses
        do_store("sb3", 32'h8000_0013, 32'h0000_00AA, 8'h01);
        do_load ("lw1", 32'h8000_0010, 8'h0f, 32'hAAAD_BEEF);
        do_load ("lh2", 32'h8000_0012, 8'h03, 32'h0000_AAAD);
        do_load ("lb1", 32'h8000_0011, 8'h01, 32'h0000_00BE);

        // Simultaneous store and load: store first, load accepted at T+4
        bus.awaddr = 32'h8000_0010; bus.wdata = 32'h5566_7788; bus.wstrb = 8'h0f;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h8000_0010; bus.rstrb = 8'h0f; bus.arvalid = 1'b1;
        @(posedge clk);
        observe(12, LAT + 2, 2 * LAT + 4, -10);
        chk("sim_wlat", first_w, LAT);
        chk("sim_wcnt", cnt_w, 1);
        chk("sim_rlat", first_r, 2 * LAT + 2);
        chk("sim_rcnt", cnt_r, 1);
        chk("sim_data", data_r, 32'h5566_7788);

        // Reset in the middle of a store abandons it
        do_store("pre", 32'h8000_0020, 32'hCAFE_F00D, 8'h0f);
        bus.awaddr = 32'h8000_0020; bus.wdata = 32'h1234_5678; bus.wstrb = 8'h0f;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        @(posedge clk);
        observe(8, 1, 0, 1);
        chk("rstmid_wcnt", cnt_w, 0);
        chk("rstmid_rcnt", cnt_r, 0);
        chk("rstmid_leak", leak, 0);
        do_load("rstmid_lw", 32'h8000_0020, 8'h0f, 32'hCAFE_F00D);

        // Address aliasing
        do_store("alias_sw", 32'h8000_1000, 32'h0BAD_F00D, 8'h0f);
        do_load ("alias_lw", 32'h8000_0000, 8'h0f, 32'h0BAD_F00D);

        // Misaligned store crossing a word boundary
        do_store("mis_pre4", 32'h8000_0004, 32'hFFFF_FFFF, 8'h0f);
        do_store("mis_pre8", 32'h8000_0008, 32'h0000_0000, 8'h0f);
        do_store("mis_sw",   32'h8000_0006, 32'h1122_3344, 8'h0f);
        do_load ("mis_lw6",  32'h8000_0006, 8'h0f, 32'h0000_3344);
        do_load ("mis_lw4",  32'h8000_0004, 8'h0f, 32'h3344_FFFF);
        do_load ("mis_lw8",  32'h8000_0008, 8'h0f, 32'h0000_0000);

        // Illegal strobe behaves as a word; byte load at offset 3
        do_load("bad_strb", 32'h8000_0004, 8'h07, 32'h3344_FFFF);
        do_load("lb3",      32'h8000_0007, 8'h01, 32'h0000_0033);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
